// File: rtl/tcam_lookup_ctrl_if.sv
// Request/response/TCAM bundle for tcam_lookup_ctrl.
// The slave modport is the controller's view; the master modport is the requester/TCAM side.
interface tcam_lookup_ctrl_if #(
  parameter int DATA_SIZE  = 4,
  parameter int ADDR_LINES = 3
);
  localparam int ENTRIES = 1 << ADDR_LINES;

  logic                  upd_valid;
  logic                  upd_ready;
  logic [ADDR_LINES-1:0] upd_addr;
  logic [DATA_SIZE-1:0]  upd_data;
  logic [DATA_SIZE-1:0]  upd_mask;

  logic                  lk0_valid;
  logic                  lk0_ready;
  logic [DATA_SIZE-1:0]  lk0_key;
  logic                  lk1_valid;
  logic                  lk1_ready;
  logic [DATA_SIZE-1:0]  lk1_key;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_id;
  logic                  rsp_hit;
  logic [ADDR_LINES-1:0] rsp_index;
  logic                  rsp_multi;

  logic                  tcam_write;
  logic                  tcam_read;
  logic [ADDR_LINES-1:0] tcam_addr;
  logic [DATA_SIZE-1:0]  tcam_data;
  logic [DATA_SIZE-1:0]  tcam_dont_care;
  logic [ENTRIES-1:0]    tcam_match;

  logic                  busy;

  modport slave (
    input  upd_valid, upd_addr, upd_data, upd_mask,
    input  lk0_valid, lk0_key, lk1_valid, lk1_key,
    input  rsp_ready, tcam_match,
    output upd_ready, lk0_ready, lk1_ready,
    output rsp_valid, rsp_id, rsp_hit, rsp_index, rsp_multi,
    output tcam_write, tcam_read, tcam_addr, tcam_data, tcam_dont_care,
    output busy
  );

  modport master (
    output upd_valid, upd_addr, upd_data, upd_mask,
    output lk0_valid, lk0_key, lk1_valid, lk1_key,
    output rsp_ready, tcam_match,
    input  upd_ready, lk0_ready, lk1_ready,
    input  rsp_valid, rsp_id, rsp_hit, rsp_index, rsp_multi,
    input  tcam_write, tcam_read, tcam_addr, tcam_data, tcam_dont_care,
    input  busy
  );
endinterface

// File: rtl/tcam_lookup_ctrl.sv
// TCAM front-end: arbitrates one update port and two lookup ports, strobes the TCAM, priority-encodes the match.
// Optional macro TCAM_CTRL_RR_EN: round-robin between the two lookup ports (default is fixed lk0 > lk1).
module tcam_lookup_ctrl #(
  parameter int DATA_SIZE  = 4,
  parameter int ADDR_LINES = 3
) (
  input  logic                clk,
  input  logic                reset,
  tcam_lookup_ctrl_if.slave   bus
);
  localparam int ENTRIES = 1 << ADDR_LINES;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    LOOKUP  = 3'd2,
    CAPTURE = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_nextState;

  logic [ADDR_LINES-1:0] r_addr;
  logic [DATA_SIZE-1:0]  r_data;
  logic [DATA_SIZE-1:0]  r_mask;
  logic                  r_lkId;

  logic                  r_rspId;
  logic                  r_rspHit;
  logic [ADDR_LINES-1:0] r_rspIndex;
  logic                  r_rspMulti;

  logic                  w_idle;
  logic                  w_pickLk1;
  logic                  w_updGrant;
  logic                  w_lk0Grant;
  logic                  w_lk1Grant;
  logic                  w_lkGrant;

  logic [ADDR_LINES-1:0] w_matchIndex;
  logic                  w_matchHit;
  logic                  w_matchMulti;

`ifdef TCAM_CTRL_RR_EN
  logic                  r_rrPtr;

  // Pointer names the lookup port to favour next: whichever was not granted last.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rrPtr <= 1'b0;
    end else if (w_lkGrant) begin
      r_rrPtr <= w_lk0Grant;
    end
  end

  always_comb begin
    w_pickLk1 = bus.lk1_valid && (!bus.lk0_valid || r_rrPtr);
  end
`else
  always_comb begin
    w_pickLk1 = bus.lk1_valid && !bus.lk0_valid;
  end
`endif

  // Grants are only offered in IDLE and never while reset is held, so nothing is accepted during reset.
  always_comb begin
    w_idle     = (r_state == IDLE) && !reset;
    w_updGrant = w_idle && bus.upd_valid;
    w_lk1Grant = w_idle && !bus.upd_valid && w_pickLk1;
    w_lk0Grant = w_idle && !bus.upd_valid && bus.lk0_valid && !w_pickLk1;
    w_lkGrant  = w_lk0Grant || w_lk1Grant;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_updGrant) begin
          w_nextState = WRITE;
        end else if (w_lkGrant) begin
          w_nextState = LOOKUP;
        end
      end
      WRITE:   w_nextState = IDLE;
      LOOKUP:  w_nextState = CAPTURE;
      CAPTURE: w_nextState = RESP;
      RESP: begin
        if (bus.rsp_ready) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Write data and search key share r_data since only one operation is ever in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr <= '0;
      r_data <= '0;
      r_mask <= '0;
      r_lkId <= 1'b0;
    end else if (w_updGrant) begin
      r_addr <= bus.upd_addr;
      r_data <= bus.upd_data;
      r_mask <= bus.upd_mask;
    end else if (w_lkGrant) begin
      r_data <= w_lk1Grant ? bus.lk1_key : bus.lk0_key;
      r_lkId <= w_lk1Grant;
    end
  end

  // Scan from the top so the lowest set bit is the one left in w_matchIndex.
  always_comb begin
    w_matchIndex = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (bus.tcam_match[i]) begin
        w_matchIndex = ADDR_LINES'(i);
      end
    end
    w_matchHit   = |bus.tcam_match;
    w_matchMulti = |(bus.tcam_match & (bus.tcam_match - ENTRIES'(1)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rspId    <= 1'b0;
      r_rspHit   <= 1'b0;
      r_rspIndex <= '0;
      r_rspMulti <= 1'b0;
    end else if (r_state == CAPTURE) begin
      r_rspId    <= r_lkId;
      r_rspHit   <= w_matchHit;
      r_rspIndex <= w_matchIndex;
      r_rspMulti <= w_matchMulti;
    end
  end

  // TCAM-side outputs depend only on state and registers, never on requester inputs.
  always_comb begin
    bus.upd_ready      = w_updGrant;
    bus.lk0_ready      = w_lk0Grant;
    bus.lk1_ready      = w_lk1Grant;

    bus.tcam_write     = (r_state == WRITE);
    bus.tcam_read      = (r_state == LOOKUP);
    bus.tcam_addr      = (r_state == WRITE) ? r_addr : '0;
    bus.tcam_data      = ((r_state == WRITE) || (r_state == LOOKUP)) ? r_data : '0;
    bus.tcam_dont_care = (r_state == WRITE) ? r_mask : '0;

    bus.rsp_valid      = (r_state == RESP);
    bus.rsp_id         = r_rspId;
    bus.rsp_hit        = r_rspHit;
    bus.rsp_index      = r_rspIndex;
    bus.rsp_multi      = r_rspMulti;

    bus.busy           = (r_state != IDLE);
  end
endmodule

// File: tb/tb_tcam_lookup_ctrl.sv
// Directed bench for tcam_lookup_ctrl with a small behavioural TCAM; honours TCAM_CTRL_RR_EN for arbitration expectations.
module tb_tcam_lookup_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

`ifdef TCAM_CTRL_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  tcam_lookup_ctrl_if #(.DATA_SIZE(4), .ADDR_LINES(3)) bus ();

  tcam_lookup_ctrl #(.DATA_SIZE(4), .ADDR_LINES(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural TCAM: mask bit 1 = compare, 0 = wildcard; match vector refreshed on a read strobe edge.
  logic [3:0] mData [8];
  logic [3:0] mMask [8];
  logic [7:0] mValid = 8'h00;
  logic [7:0] tcamMatch;

  function automatic logic [7:0] matchOf(input logic [3:0] key);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[i] = mValid[i] && (((key ^ mData[i]) & mMask[i]) == 4'b0000);
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (bus.tcam_write) begin
      mData[bus.tcam_addr]  <= bus.tcam_data;
      mMask[bus.tcam_addr]  <= bus.tcam_dont_care;
      mValid[bus.tcam_addr] <= 1'b1;
    end
    if (bus.tcam_read) begin
      tcamMatch <= matchOf(bus.tcam_data);
    end
  end

  assign bus.tcam_match = tcamMatch;

  task automatic issueWrite(input logic [2:0] a, input logic [3:0] d, input logic [3:0] m);
    int n;
    bus.upd_addr  = a;
    bus.upd_data  = d;
    bus.upd_mask  = m;
    bus.upd_valid = 1'b1;
    #1;
    n = 0;
    while (bus.upd_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    checks++;
    if (n >= 20) begin
      failures++;
      $display("[TB] FAIL wr_accept addr=%0d upd_ready=%b required=1", a, bus.upd_ready);
    end
    @(posedge clk); #1;
    bus.upd_valid = 1'b0;
    #1;
    checks++;
    if ({bus.tcam_write, bus.tcam_read, bus.tcam_addr, bus.tcam_data, bus.tcam_dont_care} !== {1'b1, 1'b0, a, d, m}) begin
      failures++;
      $display("[TB] FAIL wr_strobe got=%h required=%h",
               {bus.tcam_write, bus.tcam_read, bus.tcam_addr, bus.tcam_data, bus.tcam_dont_care}, {1'b1, 1'b0, a, d, m});
    end
    @(posedge clk); #2;
    checks++;
    if ({bus.tcam_write, bus.busy} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL wr_pulse_end write,busy=%b required=00", {bus.tcam_write, bus.busy});
    end
    @(posedge clk); #1;
  endtask

  task automatic issueLookup(input bit sel, input logic [3:0] key, input logic eId, input logic eHit,
                             input logic [2:0] eIdx, input logic eMulti, input string tag);
    int n;
    if (sel) begin
      bus.lk1_key   = key;
      bus.lk1_valid = 1'b1;
    end else begin
      bus.lk0_key   = key;
      bus.lk0_valid = 1'b1;
    end
    #1;
    n = 0;
    while ((sel ? bus.lk1_ready : bus.lk0_ready) !== 1'b1 && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    checks++;
    if (n >= 20) begin
      failures++;
      $display("[TB] FAIL %s_accept ready=0 required=1", tag);
    end
    @(posedge clk); #1;
    bus.lk0_valid = 1'b0;
    bus.lk1_valid = 1'b0;
    #1;
    checks++;
    if ({bus.tcam_read, bus.tcam_write, bus.tcam_data, bus.rsp_valid} !== {1'b1, 1'b0, key, 1'b0}) begin
      failures++;
      $display("[TB] FAIL %s_read_strobe read,write,data,rsp_valid=%b required=%b", tag,
               {bus.tcam_read, bus.tcam_write, bus.tcam_data, bus.rsp_valid}, {1'b1, 1'b0, key, 1'b0});
    end
    @(posedge clk); #2;
    checks++;
    if ({bus.tcam_read, bus.rsp_valid} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL %s_capture read,rsp_valid=%b required=00", tag, {bus.tcam_read, bus.rsp_valid});
    end
    @(posedge clk); #2;
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_hit, bus.rsp_index, bus.rsp_multi} !== {1'b1, eId, eHit, eIdx, eMulti}) begin
      failures++;
      $display("[TB] FAIL %s_resp valid,id,hit,index,multi=%b required=%b", tag,
               {bus.rsp_valid, bus.rsp_id, bus.rsp_hit, bus.rsp_index, bus.rsp_multi}, {1'b1, eId, eHit, eIdx, eMulti});
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.rsp_valid} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL %s_return_idle busy,rsp_valid=%b required=00", tag, {bus.busy, bus.rsp_valid});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.upd_addr  = 3'd2;
    bus.upd_data  = 4'b1010;
    bus.upd_mask  = 4'b1100;
    bus.upd_valid = 1'b1;
    @(posedge clk); @(posedge clk); #2;
    checks++;
    if ({bus.upd_ready, bus.lk0_ready, bus.lk1_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_hit, bus.rsp_index,
         bus.rsp_multi, bus.tcam_write, bus.tcam_read, bus.tcam_addr, bus.tcam_data, bus.tcam_dont_care, bus.busy} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got=%b required=all zero",
               {bus.upd_ready, bus.lk0_ready, bus.lk1_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_hit, bus.rsp_index,
                bus.rsp_multi, bus.tcam_write, bus.tcam_read, bus.tcam_addr, bus.tcam_data, bus.tcam_dont_care, bus.busy});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.upd_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_release_ready upd_ready=%b required=1", bus.upd_ready);
    end
    @(posedge clk); #1;
    bus.upd_valid = 1'b0;
    #1;
    checks++;
    if ({bus.tcam_write, bus.tcam_addr, bus.tcam_data, bus.tcam_dont_care} !== {1'b1, 3'd2, 4'b1010, 4'b1100}) begin
      failures++;
      $display("[TB] FAIL reset_first_write got=%b required=%b",
               {bus.tcam_write, bus.tcam_addr, bus.tcam_data, bus.tcam_dont_care}, {1'b1, 3'd2, 4'b1010, 4'b1100});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_lookup();
    issueWrite(3'd2, 4'b1010, 4'b1100);
    issueLookup(1'b0, 4'b1011, 1'b0, 1'b1, 3'd2, 1'b0, "lk0_single");
  endtask

  task automatic test_multi_match();
    issueWrite(3'd5, 4'b1000, 4'b1000);
    issueLookup(1'b1, 4'b1011, 1'b1, 1'b1, 3'd2, 1'b1, "lk1_multi");
    issueLookup(1'b1, 4'b0000, 1'b1, 1'b0, 3'd0, 1'b0, "lk1_nohit");
  endtask

  task automatic test_back_to_back();
    int got;
    int cyc;
    int last;
    logic expId;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.rsp_ready = 1'b1;
    bus.upd_addr  = 3'd7;
    bus.upd_data  = 4'b0111;
    bus.upd_mask  = 4'b1111;
    bus.lk0_key   = 4'b0111;
    bus.lk1_key   = 4'b0000;
    bus.upd_valid = 1'b1;
    bus.lk0_valid = 1'b1;
    bus.lk1_valid = 1'b1;
    #1;
    checks++;
    if ({bus.upd_ready, bus.lk0_ready, bus.lk1_ready} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL arb_upd_first readys=%b required=100", {bus.upd_ready, bus.lk0_ready, bus.lk1_ready});
    end
    @(posedge clk); #1;
    bus.upd_valid = 1'b0;
    #1;
    checks++;
    if ({bus.tcam_write, bus.upd_ready, bus.lk0_ready, bus.lk1_ready} !== 4'b1000) begin
      failures++;
      $display("[TB] FAIL arb_write_cycle write,readys=%b required=1000",
               {bus.tcam_write, bus.upd_ready, bus.lk0_ready, bus.lk1_ready});
    end
    @(posedge clk); #2;
    checks++;
    if ({bus.lk0_ready, bus.lk1_ready} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL arb_lk0_second readys=%b required=10", {bus.lk0_ready, bus.lk1_ready});
    end
    got  = 0;
    cyc  = 0;
    last = 0;
    while (got < 4 && cyc < 40) begin
      if (bus.rsp_valid === 1'b1) begin
        expId = RR ? got[0] : 1'b0;
        checks++;
        if (expId == 1'b0) begin
          if ({bus.rsp_id, bus.rsp_hit, bus.rsp_index, bus.rsp_multi} !== {1'b0, 1'b1, 3'd7, 1'b0}) begin
            failures++;
            $display("[TB] FAIL arb_resp%0d id,hit,index,multi=%b required=%b", got,
                     {bus.rsp_id, bus.rsp_hit, bus.rsp_index, bus.rsp_multi}, {1'b0, 1'b1, 3'd7, 1'b0});
          end
        end else begin
          if ({bus.rsp_id, bus.rsp_hit, bus.rsp_index, bus.rsp_multi} !== {1'b1, 1'b0, 3'd0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL arb_resp%0d id,hit,index,multi=%b required=%b", got,
                     {bus.rsp_id, bus.rsp_hit, bus.rsp_index, bus.rsp_multi}, {1'b1, 1'b0, 3'd0, 1'b0});
          end
        end
        if (got > 0) begin
          checks++;
          if (cyc - last != 4) begin
            failures++;
            $display("[TB] FAIL arb_spacing%0d cycles=%0d required=4", got, cyc - last);
          end
        end
        last = cyc;
        got++;
        if (got == 4) begin
          bus.lk0_valid = 1'b0;
          bus.lk1_valid = 1'b0;
        end
      end
      @(posedge clk); #2;
      cyc++;
    end
    checks++;
    if (got != 4) begin
      failures++;
      $display("[TB] FAIL arb_resp_count got=%0d required=4", got);
    end
    bus.lk0_valid = 1'b0;
    bus.lk1_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    checks++;
    if ({bus.busy, bus.rsp_valid} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL arb_final_idle busy,rsp_valid=%b required=00", {bus.busy, bus.rsp_valid});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    bus.rsp_ready = 1'b0;
    bus.lk0_key   = 4'b1011;
    bus.lk0_valid = 1'b1;
    #1;
    checks++;
    if (bus.lk0_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_accept lk0_ready=%b required=1", bus.lk0_ready);
    end
    @(posedge clk); #1;
    bus.lk0_valid = 1'b0;
    bus.upd_addr  = 3'd6;
    bus.upd_data  = 4'b1111;
    bus.upd_mask  = 4'b1111;
    bus.upd_valid = 1'b1;
    bus.lk1_key   = 4'b0000;
    bus.lk1_valid = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_hit, bus.rsp_index, bus.rsp_multi} !== {1'b1, 1'b0, 1'b1, 3'd2, 1'b1}) begin
        failures++;
        $display("[TB] FAIL bp_hold%0d valid,id,hit,index,multi=%b required=%b", k,
                 {bus.rsp_valid, bus.rsp_id, bus.rsp_hit, bus.rsp_index, bus.rsp_multi}, {1'b1, 1'b0, 1'b1, 3'd2, 1'b1});
      end
      checks++;
      if ({bus.tcam_write, bus.tcam_read, bus.upd_ready, bus.lk0_ready, bus.lk1_ready} !== 5'b00000) begin
        failures++;
        $display("[TB] FAIL bp_quiet%0d write,read,readys=%b required=00000", k,
                 {bus.tcam_write, bus.tcam_read, bus.upd_ready, bus.lk0_ready, bus.lk1_ready});
      end
      if (k == 4) begin
        bus.upd_valid = 1'b0;
        bus.lk1_valid = 1'b0;
        bus.rsp_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.rsp_valid} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL bp_release_idle busy,rsp_valid=%b required=00", {bus.busy, bus.rsp_valid});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_capture();
    bus.rsp_ready = 1'b1;
    bus.lk0_key   = 4'b1011;
    bus.lk0_valid = 1'b1;
    #1;
    checks++;
    if (bus.lk0_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rst_mid_accept lk0_ready=%b required=1", bus.lk0_ready);
    end
    @(posedge clk); #1;
    bus.lk0_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.rsp_valid, bus.tcam_read, bus.tcam_write} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL rst_mid_abort busy,rsp_valid,read,write=%b required=0000",
               {bus.busy, bus.rsp_valid, bus.tcam_read, bus.tcam_write});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if ({bus.busy, bus.rsp_valid, bus.tcam_read, bus.tcam_write} !== 4'b0000) begin
        failures++;
        $display("[TB] FAIL rst_mid_quiet%0d busy,rsp_valid,read,write=%b required=0000", k,
                 {bus.busy, bus.rsp_valid, bus.tcam_read, bus.tcam_write});
      end
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b0;
    issueLookup(1'b0, 4'b1011, 1'b0, 1'b1, 3'd2, 1'b1, "post_reset");
  endtask

  task automatic test_all_match();
    for (int a = 0; a < 8; a++) begin
      issueWrite(3'(a), 4'b0000, 4'b0000);
    end
    issueLookup(1'b1, 4'b0110, 1'b1, 1'b1, 3'd0, 1'b1, "all_ones");
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset         = 1'b1;
    bus.upd_valid = 1'b0;
    bus.upd_addr  = '0;
    bus.upd_data  = '0;
    bus.upd_mask  = '0;
    bus.lk0_valid = 1'b0;
    bus.lk0_key   = '0;
    bus.lk1_valid = 1'b0;
    bus.lk1_key   = '0;
    bus.rsp_ready = 1'b0;

    test_reset();
    test_write_lookup();
    test_multi_match();
    test_back_to_back();
    test_backpressure();
    test_reset_capture();
    test_all_match();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
